// File: rtl/rand_range_prefetch.sv
// Purpose : prefetch raw 32-bit random values, reduce each to [0, BOUND) by
//           mask-and-reject, and queue accepted results for a valid/ready consumer.
// Latency : a value accepted in cycle t is presented on OUT_DATA in cycle t+1.
//           There is no combinational path from RAND_IN to OUT_DATA.
// Backpressure: the source is not strobed while the FIFO holds DEPTH entries.
//           OUT_READY never feeds RAND_REQ, so a pop frees a slot one cycle later.
// Ports   : CLK/RESET     clock and synchronous active-high reset
//           ENABLE        permits new requests to the source
//           RAND_IN       current source value
//           RAND_REQ      consume strobe back to the source
//           OUT_DATA      FIFO head value
//           OUT_VALID     FIFO is non-empty
//           OUT_READY     consumer handshake
//           REJECT_CNT    saturating count of rejected raw values
module rand_range_prefetch #(
    parameter longint unsigned BOUND = 100,
    parameter int              DEPTH = 4,
    parameter int              CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [31:0]      RAND_IN,
    output logic             RAND_REQ,
    output logic [31:0]      OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] REJECT_CNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // MASK is the smallest all-ones value covering BOUND-1.
    // BOUND=1 gives a zero mask, so every candidate is 0 and is accepted.
    localparam int          BW      = (BOUND <= 1) ? 0 : $clog2(BOUND);
    localparam logic [31:0] MASK    = 32'((64'd1 << BW) - 64'd1);
    localparam logic [32:0] BOUND_W = 33'(BOUND);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    logic [31:0] cand;
    logic        accept;
    logic        push;
    logic        pop;

    assign cand   = RAND_IN & MASK;
    assign accept = ({1'b0, cand} < BOUND_W);

    // The request depends only on registered occupancy.
    // This keeps the strobe independent of the consumer's ready signal.
    assign RAND_REQ  = ENABLE & ~RESET & (count_q != FULL);
    assign OUT_VALID = (count_q != '0);
    assign OUT_DATA  = OUT_VALID ? mem_q[head_q] : 32'h0;
    assign REJECT_CNT = rej_q;

    assign push = RAND_REQ & accept;
    assign pop  = OUT_VALID & OUT_READY;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rej_d   = rej_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (RAND_REQ && !accept && (rej_q != '1)) begin
            rej_d = rej_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rej_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rej_q   <= rej_d;
        end
    end

    // Storage is not reset.
    // Stale entries are unreachable because OUT_VALID is derived from count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[tail_q] <= cand;
        end
    end

endmodule

// File: tb/tb_rand_range_prefetch.sv
module tb_rand_range_prefetch;

    logic        clk;
    // DUT A: BOUND=100, DEPTH=4, CNT_W=16
    logic        rst_a, en_a, rdy_a;
    logic [31:0] rin_a;
    logic        req_a, vld_a;
    logic [31:0] dat_a;
    logic [15:0] rej_a;
    // DUT B: BOUND=65, DEPTH=4, CNT_W=4 (saturation)
    logic        rst_b, en_b, rdy_b;
    logic [31:0] rin_b;
    logic        req_b, vld_b;
    logic [31:0] dat_b;
    logic [3:0]  rej_b;

    int vectors;
    int miscompares;

    rand_range_prefetch #(.BOUND(100), .DEPTH(4), .CNT_W(16)) dut_a (
        .CLK(clk), .RESET(rst_a), .ENABLE(en_a), .RAND_IN(rin_a),
        .RAND_REQ(req_a), .OUT_DATA(dat_a), .OUT_VALID(vld_a),
        .OUT_READY(rdy_a), .REJECT_CNT(rej_a)
    );

    rand_range_prefetch #(.BOUND(65), .DEPTH(4), .CNT_W(4)) dut_b (
        .CLK(clk), .RESET(rst_b), .ENABLE(en_b), .RAND_IN(rin_b),
        .RAND_REQ(req_b), .OUT_DATA(dat_b), .OUT_VALID(vld_b),
        .OUT_READY(rdy_b), .REJECT_CNT(rej_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each row is driven after a falling edge and checked before the next rising edge.
    // Expected outputs reflect state from earlier rows plus this row's inputs.
    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        logic [31:0] rin;
        bit          req;
        bit          vld;
        logic [31:0] dat;
        logic [15:0] rej;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit rst, input bit en, input bit rdy, input logic [31:0] rin,
                       input bit req, input bit vld, input logic [31:0] dat,
                       input logic [15:0] rej);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.rin = rin;
        v.req = req; v.vld = vld; v.dat = dat; v.rej = rej;
        vq.push_back(v);
    endtask

    task automatic check_b(input string name, input bit req, input bit vld,
                           input logic [31:0] dat, input logic [3:0] rej);
        vectors++;
        if (req_b !== req || vld_b !== vld || dat_b !== dat || rej_b !== rej) begin
            miscompares++;
            $display("FAIL %s: got req=%0b vld=%0b dat=%0d rej=%0d, want req=%0b vld=%0b dat=%0d rej=%0d",
                     name, req_b, vld_b, dat_b, rej_b, req, vld, dat, rej);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_a = 1'b1; en_a = 1'b1; rdy_a = 1'b1; rin_a = 32'h0;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0; rin_b = 32'h0;

        //   rst en rdy rin           req vld dat  rej
        // Reset state.
        add(1, 1, 1, 32'h0,         0, 0, 0,   0);
        // Accept 0x105 -> 5.
        add(0, 1, 1, 32'h00000105,  1, 0, 0,   0);
        // Reject cand 112 while 5 is popped.
        add(0, 1, 1, 32'hFFFFFF70,  1, 1, 5,   0);
        add(0, 1, 1, 32'h63,        1, 0, 0,   1);
        add(0, 0, 1, 32'h0,         0, 1, 99,  1);
        // Fill with OUT_READY=0.
        add(0, 1, 0, 32'd1,         1, 0, 0,   1);
        add(0, 1, 0, 32'd2,         1, 1, 1,   1);
        add(0, 1, 0, 32'd3,         1, 1, 1,   1);
        add(0, 1, 0, 32'd4,         1, 1, 1,   1);
        add(0, 1, 0, 32'd5,         0, 1, 1,   1);
        // First pop happens at full.
        // The request returns one cycle later.
        add(0, 1, 1, 32'd6,         0, 1, 1,   1);
        add(0, 1, 1, 32'd7,         1, 1, 2,   1);
        add(0, 0, 1, 32'd0,         0, 1, 3,   1);
        add(0, 0, 1, 32'd0,         0, 1, 4,   1);
        add(0, 0, 1, 32'd0,         0, 1, 7,   1);
        add(0, 0, 1, 32'd0,         0, 0, 0,   1);
        // Bring the count to 2.
        // Then push and pop together for 12 cycles, wrapping the pointers.
        add(0, 1, 0, 32'd10,        1, 0, 0,   1);
        add(0, 1, 0, 32'd11,        1, 1, 10,  1);
        for (int i = 0; i < 12; i++) begin
            add(0, 1, 1, 32'(12 + i), 1, 1, 32'(10 + i), 1);
        end
        // Drain exactly two entries, confirming the count stayed 2.
        add(0, 0, 1, 32'd0,         0, 1, 22,  1);
        add(0, 0, 1, 32'd0,         0, 1, 23,  1);
        add(0, 0, 1, 32'd0,         0, 0, 0,   1);
        // Reset mid-operation with count 3.
        add(0, 1, 0, 32'd30,        1, 0, 0,   1);
        add(0, 1, 0, 32'd31,        1, 1, 30,  1);
        add(0, 1, 0, 32'h7F,        1, 1, 30,  1);
        add(0, 1, 0, 32'd32,        1, 1, 30,  2);
        add(1, 1, 0, 32'd33,        0, 1, 30,  2);
        add(0, 1, 0, 32'd34,        1, 0, 0,   0);
        add(0, 1, 1, 32'd35,        1, 1, 34,  0);
        add(0, 0, 1, 32'd0,         0, 1, 35,  0);
        add(0, 0, 1, 32'd0,         0, 0, 0,   0);
        // Bound edges: 100 is rejected; 0xE3 masks to 99 and is accepted.
        add(0, 1, 1, 32'd100,       1, 0, 0,   0);
        add(0, 1, 1, 32'hE3,        1, 0, 0,   1);
        add(0, 0, 1, 32'd0,         0, 1, 99,  1);
        add(0, 0, 1, 32'd0,         0, 0, 0,   1);

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_a = vq[i].rst; en_a = vq[i].en; rdy_a = vq[i].rdy; rin_a = vq[i].rin;
            #1;
            vectors++;
            if (req_a !== vq[i].req || vld_a !== vq[i].vld ||
                dat_a !== vq[i].dat || rej_a !== vq[i].rej) begin
                miscompares++;
                $display("FAIL row%0d: got req=%0b vld=%0b dat=%0d rej=%0d, want req=%0b vld=%0b dat=%0d rej=%0d",
                         i, req_a, vld_a, dat_a, rej_a,
                         vq[i].req, vq[i].vld, vq[i].dat, vq[i].rej);
            end
        end

        // Saturation on DUT B.
        // The constant input 127 is always rejected against bound 65.
        @(negedge clk);
        rst_b = 1'b0; en_b = 1'b1; rdy_b = 1'b1; rin_b = 32'd127;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_b($sformatf("sat%0d", i), 1'b1, 1'b0, 32'h0, 4'((i > 15) ? 15 : i));
            @(negedge clk);
        end
        rin_b = 32'd64;
        #1;
        check_b("sat_hold", 1'b1, 1'b0, 32'h0, 4'd15);
        @(negedge clk);
        en_b = 1'b0;
        #1;
        check_b("accept64", 1'b0, 1'b1, 32'd64, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
